// File: rtl/codec_init_seq.sv
// ---------------------------------------------------------------------------
// codec_init_seq : steps an I2C writer through an 11-word codec init table
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module codec_init_seq #(
  parameter int GAP_CYC = 4,
  parameter int TIMEOUT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        go,
  input  logic        i2c_busy,
  output logic        i2c_start,
  output logic [15:0] i2c_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  idx
);

  localparam int             TO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [3:0]     GAP_LAST = 4'(GAP_CYC);
  localparam logic [3:0]     IDX_LAST = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      idx_nx;
  logic [15:0]     data_nx;
  logic            start_nx, busy_nx, done_nx, err_nx;
  logic [3:0]      gap_cnt, gap_cnt_nx;
  logic [TO_W-1:0] to_cnt, to_cnt_nx;

  // Words are {reg_addr[6:0], value[8:0]}
  function automatic logic [15:0] entry(input logic [3:0] i);
    case (i)
      4'd0:    entry = 16'h1E00;
      4'd1:    entry = 16'h0017;
      4'd2:    entry = 16'h0217;
      4'd3:    entry = 16'h0479;
      4'd4:    entry = 16'h0679;
      4'd5:    entry = 16'h0812;
      4'd6:    entry = 16'h0A00;
      4'd7:    entry = 16'h0C00;
      4'd8:    entry = 16'h0E02;
      4'd9:    entry = 16'h1000;
      4'd10:   entry = 16'h1201;
      default: entry = 16'h0000;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      i2c_data  <= 16'h0000;
      i2c_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      gap_cnt   <= 4'd0;
      to_cnt    <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      i2c_data  <= data_nx;
      i2c_start <= start_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      gap_cnt   <= gap_cnt_nx;
      to_cnt    <= to_cnt_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    data_nx    = i2c_data;
    start_nx   = 1'b0;
    busy_nx    = busy;
    done_nx    = done;
    err_nx     = err;
    gap_cnt_nx = gap_cnt;
    to_cnt_nx  = to_cnt;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          state_nx   = S_ISSUE;
          idx_nx     = 4'd0;
          data_nx    = entry(4'd0);
          start_nx   = 1'b1;
          busy_nx    = 1'b1;
          done_nx    = 1'b0;
          err_nx     = 1'b0;
          gap_cnt_nx = 4'd0;
          to_cnt_nx  = '0;
        end
      end

      // to_cnt tracks cycles elapsed since i2c_start was raised
      S_ISSUE: begin
        state_nx  = S_WAIT_HI;
        to_cnt_nx = TO_W'(1);
      end

      S_WAIT_HI: begin
        if (i2c_busy) begin
          state_nx = S_WAIT_LO;
        end else if (to_cnt >= TO_LAST) begin
          state_nx = S_ERR;
          busy_nx  = 1'b0;
          err_nx   = 1'b1;
        end else begin
          to_cnt_nx = to_cnt + TO_W'(1);
        end
      end

      S_WAIT_LO: begin
        if (!i2c_busy) begin
          state_nx   = S_GAP;
          gap_cnt_nx = 4'd0;
        end
      end

      // Leaves on the (GAP_CYC+1)th edge after busy was seen low
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          if (idx == IDX_LAST) begin
            state_nx = S_DONE;
            done_nx  = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            state_nx  = S_ISSUE;
            idx_nx    = idx + 4'd1;
            data_nx   = entry(idx + 4'd1);
            start_nx  = 1'b1;
            to_cnt_nx = '0;
          end
        end else begin
          gap_cnt_nx = gap_cnt + 4'd1;
        end
      end

      default: begin
        state_nx = S_IDLE;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire
